// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned NOP_INSTR = 0;
    localparam int unsigned PC_INCR   = 4;

    typedef enum logic [1:0] {
        StFetch,
        StDrop,
        StHeld
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes contents, clear inserts a bubble, otherwise load.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hold_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] instr_d, instr_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_d, pc_plus4_q;

    // Hold wins over clear so a stalled ID never loses its instruction.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (!hold_i) begin
            if (clear_i) begin
                valid_d = 1'b0;
                instr_d = DATA_WIDTH'(NOP_INSTR);
            end else begin
                valid_d    = 1'b1;
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack handshake with variable-latency imem, skid buffer and IF/ID drive.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_if_i,
    input  logic                  stall_id_i,
    input  logic                  id_branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] id_branch_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  id_valid_o,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4_o
);

    fetch_state_e          state_d, state_q;
    logic [ADDR_WIDTH-1:0] pc_d, pc_q;
    logic [ADDR_WIDTH-1:0] req_addr_d, req_addr_q;
    logic                  req_active_d, req_active_q;
    logic [DATA_WIDTH-1:0] skid_instr_d, skid_instr_q;
    logic [ADDR_WIDTH-1:0] skid_pc4_d, skid_pc4_q;

    logic                  ack;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] req_next;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  ifid_clear;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [ADDR_WIDTH-1:0] ifid_pc4;

    // An ack with no request outstanding is meaningless and ignored.
    assign ack      = req_active_q & imem_ack_i;
    assign redirect = id_branch_taken_i & ~stall_id_i;
    assign req_next = req_addr_q + ADDR_WIDTH'(PC_INCR);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        req_active_d = req_active_q & ~imem_ack_i;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_clear   = 1'b1;
        ifid_instr   = imem_rdata_i;
        ifid_pc4     = req_next;
        issue        = 1'b0;
        issue_addr   = pc_q;

        unique case (state_q)
            StFetch: begin
                if (ack) begin
                    if (stall_id_i) begin
                        skid_instr_d = imem_rdata_i;
                        skid_pc4_d   = req_next;
                        pc_d         = req_next;
                        state_d      = StHeld;
                    end else if (redirect) begin
                        pc_d = id_branch_target_i;
                    end else begin
                        ifid_clear = 1'b0;
                        pc_d       = req_next;
                        issue      = ~stall_if_i;
                        issue_addr = req_next;
                    end
                end else if (redirect) begin
                    pc_d = id_branch_target_i;
                    if (req_active_q) begin
                        state_d = StDrop;
                    end
                end else if (!req_active_q && !stall_if_i) begin
                    issue = 1'b1;
                end
            end
            StDrop: begin
                if (redirect) begin
                    pc_d = id_branch_target_i;
                end
                if (ack) begin
                    state_d = StFetch;
                end
            end
            StHeld: begin
                if (!stall_id_i) begin
                    state_d = StFetch;
                    if (redirect) begin
                        pc_d = id_branch_target_i;
                    end else begin
                        ifid_clear = 1'b0;
                        ifid_instr = skid_instr_q;
                        ifid_pc4   = skid_pc4_q;
                        issue      = ~stall_if_i;
                    end
                end
            end
            default: state_d = StFetch;
        endcase

        if (issue) begin
            req_active_d = 1'b1;
            req_addr_d   = issue_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_active_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_active_q <= req_active_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .hold_i     (stall_id_i),
        .clear_i    (ifid_clear),
        .instr_i    (ifid_instr),
        .pc_plus4_i (ifid_pc4),
        .valid_o    (id_valid_o),
        .instr_o    (id_instr_o),
        .pc_plus4_o (id_pc_plus4_o)
    );

    assign imem_req_o  = req_active_q;
    assign imem_addr_o = req_addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait stream, waits, skid, redirects, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_ni;
    logic        stall_if;
    logic        stall_id;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;

    int checks;
    int failures;

    fetch_stage u_dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .stall_if_i         (stall_if),
        .stall_id_i         (stall_id),
        .id_branch_taken_i  (br_taken),
        .id_branch_target_i (br_target),
        .imem_req_o         (imem_req),
        .imem_addr_o        (imem_addr),
        .imem_ack_i         (imem_ack),
        .imem_rdata_i       (imem_rdata),
        .id_valid_o         (id_valid),
        .id_instr_o         (id_instr),
        .id_pc_plus4_o      (id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle, leaving time to sample and re-drive inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc4);
        check({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, "_instr"}, id_instr, ins);
        check({tag, "_pc4"}, id_pc_plus4, pc4);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) check({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_ni     = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;

        // Reset held for three edges.
        repeat (3) step();
        check_req("rst", 1'b0, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check_id("rst", 1'b0, 32'h0, 32'h0);

        rst_ni = 1'b1;
        step();
        check_req("first", 1'b1, 32'h0);

        // Zero-wait stream.
        imem_ack = 1'b1;
        imem_rdata = 32'h11;
        step();
        check_id("zw1", 1'b1, 32'h11, 32'h4);
        check_req("zw1", 1'b1, 32'h4);
        imem_rdata = 32'h22;
        step();
        check_id("zw2", 1'b1, 32'h22, 32'h8);
        check_req("zw2", 1'b1, 32'h8);
        imem_rdata = 32'h33;
        step();
        check_id("zw3", 1'b1, 32'h33, 32'hc);
        check_req("zw3", 1'b1, 32'hc);
        imem_rdata = 32'h44;
        step();
        check_id("zw4", 1'b1, 32'h44, 32'h10);
        check_req("zw4", 1'b1, 32'h10);

        // Three wait cycles at 0x10: one bubble each, address stable.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_valid", {31'd0, id_valid}, 32'd0);
            check("wait_instr", id_instr, 32'h0);
            check_req("wait", 1'b1, 32'h10);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h55;
        step();
        check_id("wait_done", 1'b1, 32'h55, 32'h14);
        check_req("wait_done", 1'b1, 32'h14);

        // Return while ID stalled: skid holds it, no requests while held.
        imem_rdata = 32'h66;
        stall_id = 1'b1;
        step();
        check_req("held1", 1'b0, 32'h0);
        check_id("held1", 1'b1, 32'h55, 32'h14);
        imem_ack = 1'b0;
        step();
        check_req("held2", 1'b0, 32'h0);
        check_id("held2", 1'b1, 32'h55, 32'h14);
        stall_id = 1'b0;
        step();
        check_id("release", 1'b1, 32'h66, 32'h18);
        check_req("release", 1'b1, 32'h18);
        step();
        check("no_dup_valid", {31'd0, id_valid}, 32'd0);
        check_req("no_dup", 1'b1, 32'h18);

        // Walk up to a pending request at 0x20.
        imem_ack = 1'b1;
        imem_rdata = 32'h77;
        step();
        check_id("walk1", 1'b1, 32'h77, 32'h1c);
        imem_rdata = 32'h88;
        step();
        check_id("walk2", 1'b1, 32'h88, 32'h20);
        check_req("walk2", 1'b1, 32'h20);
        imem_ack = 1'b0;
        step();
        check_req("pend", 1'b1, 32'h20);

        // Redirect mid-request: outstanding 0x20 response must be dropped.
        br_taken = 1'b1;
        br_target = 32'h100;
        step();
        check("drop_valid", {31'd0, id_valid}, 32'd0);
        check_req("drop", 1'b1, 32'h20);
        br_taken = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hdead;
        step();
        check("dropped_valid", {31'd0, id_valid}, 32'd0);
        check("dropped_instr", id_instr, 32'h0);
        check_req("dropped", 1'b0, 32'h0);
        imem_ack = 1'b0;
        step();
        check_req("target", 1'b1, 32'h100);
        check("target_valid", {31'd0, id_valid}, 32'd0);

        // Redirect coinciding with ack: data discarded, no same-cycle fetch.
        imem_ack = 1'b1;
        imem_rdata = 32'h99;
        br_taken = 1'b1;
        br_target = 32'hffff_fffc;
        step();
        check("redir_ack_valid", {31'd0, id_valid}, 32'd0);
        check_req("redir_ack", 1'b0, 32'h0);
        br_taken = 1'b0;
        imem_ack = 1'b0;
        step();
        check_req("wrap_req", 1'b1, 32'hffff_fffc);

        // PC+4 wraps modulo 2^32.
        imem_ack = 1'b1;
        imem_rdata = 32'hab;
        step();
        check_id("wrap", 1'b1, 32'hab, 32'h0);
        check_req("wrap", 1'b1, 32'h0);

        // Asynchronous reset mid-request, sampled before any further edge.
        imem_ack = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_req("async_rst", 1'b0, 32'h0);
        check("async_rst_valid", {31'd0, id_valid}, 32'd0);
        check("async_rst_instr", id_instr, 32'h0);
        check("async_rst_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
